// File: rtl/div5_seq_checker.sv
// Sequential divisible-by-5 checker: sums a word's nibbles mod 5, one nibble per cycle.
// Optional saturating result counters when DIV5_STATS_EN is defined.
module div5_seq_checker #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_div5,
  output logic [2:0]       out_rem,
  output logic             busy
`ifdef DIV5_STATS_EN
  ,
  output logic [15:0]      stat_total,
  output logic [15:0]      stat_div
`endif
);

  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shreg_reg;
  logic [2:0]       rem_reg;
  logic [CW-1:0]    cnt_reg;
  logic             in_ready_reg;
  logic             out_valid_reg;
  logic             out_div5_reg;
  logic [2:0]       out_rem_reg;
  logic             busy_reg;

  logic [4:0] sum_next;
  logic [2:0] rem_next;

  // Since 16 == 1 (mod 5), adding each nibble to the running remainder
  // and folding back into 0..4 yields the remainder of the whole word.
  always_comb begin
    sum_next = {2'b00, rem_reg} + {1'b0, shreg_reg[3:0]};
    if (sum_next >= 5'd15)
      rem_next = 3'(sum_next - 5'd15);
    else if (sum_next >= 5'd10)
      rem_next = 3'(sum_next - 5'd10);
    else if (sum_next >= 5'd5)
      rem_next = 3'(sum_next - 5'd5);
    else
      rem_next = sum_next[2:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      shreg_reg     <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_div5_reg  <= 1'b0;
      out_rem_reg   <= '0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            shreg_reg    <= in_word;
            rem_reg      <= '0;
            cnt_reg      <= CW'(NIB - 1);
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          rem_reg   <= rem_next;
          shreg_reg <= shreg_reg >> 4;
          if (cnt_reg == '0) begin
            // Results are registered on the final nibble so they appear with out_valid.
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            out_rem_reg   <= rem_next;
            out_div5_reg  <= (rem_next == 3'd0);
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_div5  = out_div5_reg;
  assign out_rem   = out_rem_reg;
  assign busy      = busy_reg;

`ifdef DIV5_STATS_EN
  logic [15:0] stat_total_reg;
  logic [15:0] stat_div_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total_reg <= '0;
      stat_div_reg   <= '0;
    end else if (out_valid_reg && out_ready) begin
      if (stat_total_reg != 16'hFFFF)
        stat_total_reg <= stat_total_reg + 16'd1;
      if (out_div5_reg && (stat_div_reg != 16'hFFFF))
        stat_div_reg <= stat_div_reg + 16'd1;
    end
  end

  assign stat_total = stat_total_reg;
  assign stat_div   = stat_div_reg;
`endif

endmodule

// File: tb/tb_div5_seq_checker.sv
// Directed and swept checks of div5_seq_checker at WIDTH=16 and WIDTH=4.
module tb_div5_seq_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_valid4;
  logic        in_ready, in_ready4;
  logic [15:0] in_word;
  logic [3:0]  in_word4;
  logic        out_valid, out_valid4;
  logic        out_ready, out_ready4;
  logic        out_div5, out_div54;
  logic [2:0]  out_rem, out_rem4;
  logic        busy, busy4;
`ifdef DIV5_STATS_EN
  logic [15:0] stat_total, stat_div, stat_total4, stat_div4;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  div5_seq_checker #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_div5(out_div5), .out_rem(out_rem), .busy(busy)
`ifdef DIV5_STATS_EN
    , .stat_total(stat_total), .stat_div(stat_div)
`endif
  );

  div5_seq_checker #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_word(in_word4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_div5(out_div54), .out_rem(out_rem4), .busy(busy4)
`ifdef DIV5_STATS_EN
    , .stat_total(stat_total4), .stat_div(stat_div4)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full transaction on the 16-bit instance with expected remainder from the bench.
  task automatic word16(input logic [15:0] w, input logic [2:0] exp_rem, input string tag);
    int n;
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_word  = w;
    tick();
    in_valid = 1'b0;
    in_word  = 16'(~w);  // must be ignored after the accept edge
    n = 0;
    while (!out_valid && n < 12) begin
      tick();
      n++;
    end
    check({tag, "_latency"}, 32'(n), 32'd4);
    check({tag, "_rem"}, 32'(out_rem), 32'(exp_rem));
    check({tag, "_div5"}, 32'(out_div5), 32'(exp_rem == 3'd0));
    $display("W16 %s word=0x%04h rem=%0d div5=%0d lat=%0d", tag, w, out_rem, out_div5, n);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_ovalid_drop"}, 32'(out_valid), 32'd0);
  endtask

  task automatic word4(input logic [3:0] w, input logic [2:0] exp_rem);
    int n;
    in_valid4 = 1'b1;
    in_word4  = w;
    tick();
    in_valid4 = 1'b0;
    n = 0;
    while (!out_valid4 && n < 8) begin
      tick();
      n++;
    end
    check("w4_latency", 32'(n), 32'd1);
    check("w4_rem", 32'(out_rem4), 32'(exp_rem));
    check("w4_div5", 32'(out_div54), 32'(exp_rem == 3'd0));
    $display("W4 word=0x%0h rem=%0d div5=%0d", w, out_rem4, out_div54);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    tick();
  endtask

  initial begin
    logic [15:0] rw;
    logic [3:0]  rw4;
    rst = 1'b1;
    in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_word4 = '0; out_ready4 = 1'b0;
    #1;
    // Reset values
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_div5", 32'(out_div5), 32'd0);
    check("rst_rem", 32'(out_rem), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed words
    word16(16'h0000, 3'd0, "zero");
    tick();
    word16(16'h0007, 3'd2, "w0007");
    tick();
    word16(16'hFFFE, 3'd4, "wFFFE");
    tick();
    word16(16'h1234, 3'd0, "w1234");
    tick();
    word16(16'hFFFF, 3'd0, "ones");
    tick();

    // Backpressure: result held while out_ready is low
    in_valid = 1'b1; in_word = 16'h0003;
    tick();
    in_valid = 1'b0;
    check("bp_busy_run", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) tick();
    tick();
    check("bp_valid_up", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_rem", 32'(out_rem), 32'd3);
      check("bp_hold_div5", 32'(out_div5), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;  // must not be accepted while busy
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_ready", 32'(in_ready), 32'd1);
    check("bp_idle_busy", 32'(busy), 32'd0);
    check("bp_idle_valid", 32'(out_valid), 32'd0);
    $display("W16 backpressure word=0x0003 held 5 cycles");

    // out_ready while idle has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_oready_valid", 32'(out_valid), 32'd0);

    // Reset in the 2nd RUN cycle
    in_valid = 1'b1; in_word = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rem", 32'(out_rem), 32'd0);
    check("abort_div5", 32'(out_div5), 32'd0);
    $display("W16 abort word=0xFFFF reset in RUN");
    tick();
    rst = 1'b0;
    tick();
    word16(16'h000A, 3'd0, "after_abort");
    tick();

    // Random sweep against golden word % 5
    for (int i = 0; i < 1000; i++) begin
      rw = 16'($urandom);
      word16(rw, 3'(rw % 16'd5), "sweep16");
    end
    for (int i = 0; i < 1000; i++) begin
      rw4 = 4'($urandom);
      word4(rw4, 3'(rw4 % 4'd5));
    end

`ifdef DIV5_STATS_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check("stat_rst_total", 32'(stat_total), 32'd0);
    check("stat_rst_div", 32'(stat_div), 32'd0);
    word16(16'd5, 3'd0, "stat5");
    word16(16'd6, 3'd1, "stat6");
    word16(16'd10, 3'd0, "stat10");
    check("stat_total", 32'(stat_total), 32'd3);
    check("stat_div", 32'(stat_div), 32'd2);
    force dut.stat_total_reg = 16'hFFFF;
    force dut.stat_div_reg   = 16'hFFFF;
    #1;
    release dut.stat_total_reg;
    release dut.stat_div_reg;
    word16(16'd5, 3'd0, "stat_sat");
    check("stat_total_sat", 32'(stat_total), 32'hFFFF);
    check("stat_div_sat", 32'(stat_div), 32'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
